// File: rtl/reg_file_2r1w.sv
// Register file: DEPTH x WIDTH, two combinational read ports, one synchronous write port,
// optional zero register and write-to-read bypass, plus a word-per-cycle clear engine.
module reg_file_2r1w #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    input  logic              clear_req,
    output logic              busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic wr_ok;
    logic zero_a, zero_b;
    logic byp_a, byp_b;

    assign wr_ok = we && (state == IDLE) && !((ZERO_REG != 0) && (waddr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state <= CLEAR;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    ptr <= ptr + ADDR_W'(1);
                    if (ptr == '1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // A write on the edge that accepts clear_req still lands; the engine clears it later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '{default: '0};
        end else if (state == CLEAR) begin
            mem[ptr] <= '0;
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        zero_a = (ZERO_REG != 0) && (raddr_a == '0);
        zero_b = (ZERO_REG != 0) && (raddr_b == '0);
        byp_a  = (BYPASS != 0) && we && (state == IDLE) && (waddr == raddr_a);
        byp_b  = (BYPASS != 0) && we && (state == IDLE) && (waddr == raddr_b);
        rdata_a = mem[raddr_a];
        rdata_b = mem[raddr_b];
        if (byp_a) rdata_a = wdata;
        if (byp_b) rdata_b = wdata;
        if (zero_a) rdata_a = '0;
        if (zero_b) rdata_b = '0;
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench: dut uses default parameters, dut2 has ZERO_REG=0 and BYPASS=0, same inputs.
module tb_reg_file_2r1w;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic [3:0]  ra, rb;
    logic        clear_req;
    logic [15:0] rdata_a, rdata_b, rdata_a2, rdata_b2;
    logic        busy, busy2;

    int meas;
    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] exp;
    } chk_t;

    chk_t q[$];
    event ev_sample;

    always #5 clk = ~clk;

    reg_file_2r1w dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(ra), .rdata_a(rdata_a), .raddr_b(rb), .rdata_b(rdata_b),
        .clear_req(clear_req), .busy(busy)
    );

    reg_file_2r1w #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(ra), .rdata_a(rdata_a2), .raddr_b(rb), .rdata_b(rdata_b2),
        .clear_req(clear_req), .busy(busy2)
    );

    // Monitor: drains every queued expectation whenever the stimulus signals a sample point.
    initial begin
        chk_t        c;
        logic [15:0] act;
        forever begin
            @(ev_sample);
            while (q.size() > 0) begin
                c = q.pop_front();
                case (c.sel)
                    0: act = rdata_a;
                    1: act = rdata_b;
                    2: act = {15'b0, busy};
                    3: act = rdata_a2;
                    4: act = rdata_b2;
                    5: act = {15'b0, busy2};
                    default: act = meas[15:0];
                endcase
                n_chk++;
                if (act === c.exp) n_pass++;
                else $display("FAIL %s: got 0x%04h expected 0x%04h", c.name, act, c.exp);
            end
        end
    end

    task automatic expect_(input string name, input int sel, input logic [15:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        q.push_back(c);
    endtask

    task automatic sample();
        #1;
        -> ev_sample;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [3:0] a, input logic [15:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    // Runs the clear to completion from an accepted request; optional mid-clear actions.
    task automatic run_clear(input bit disturb);
        meas = 0;
        while (busy && meas < 40) begin
            meas++;
            if (!disturb && meas == 9) begin
                ra = 4'd7; rb = 4'd9;
                expect_("clr_ptr8_r7", 0, 16'h0000);
                expect_("clr_ptr8_r9", 1, 16'hA5A5);
                sample();
            end
            if (disturb && meas == 12) begin
                we = 1'b1; waddr = 4'd9; wdata = 16'h7777; clear_req = 1'b1;
                ra = 4'd9; rb = 4'd2;
                expect_("busy_no_bypass_r9", 0, 16'h0000);
                expect_("busy_r2_cleared", 1, 16'h0000);
                sample();
            end
            tick();
            we = 1'b0; clear_req = 1'b0;
        end
        expect_("busy_cycles", 6, 16'd16);
        expect_("busy_low_after", 2, 16'h0000);
        expect_("busy2_low_after", 5, 16'h0000);
        sample();
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        ra = '0; rb = '0; clear_req = 1'b0; meas = 0;
        #12;
        ra = 4'd3; rb = 4'd15;
        expect_("reset_rdata_a", 0, 16'h0000);
        expect_("reset_busy", 2, 16'h0000);
        sample();
        rst_n = 1'b1;
        tick();

        write(4'd3, 16'h1234);
        write(4'd15, 16'hBEEF);
        expect_("wr_r3", 0, 16'h1234);
        expect_("wr_r15", 1, 16'hBEEF);
        sample();
        rst_n = 1'b0;
        expect_("async_rst_a", 0, 16'h0000);
        expect_("async_rst_b", 1, 16'h0000);
        expect_("async_rst_a2", 3, 16'h0000);
        sample();
        rst_n = 1'b1;
        tick();

        // Zero register, including the cycle of the write with bypass enabled.
        we = 1'b1; waddr = 4'd0; wdata = 16'hFFFF; ra = 4'd0; rb = 4'd0;
        expect_("zero_bypass_cycle", 0, 16'h0000);
        expect_("nozero_before_edge", 3, 16'h0000);
        sample();
        tick();
        we = 1'b0;
        expect_("zero_after_edge", 0, 16'h0000);
        expect_("nozero_after_edge", 3, 16'hFFFF);
        sample();

        // Bypass on both ports.
        write(4'd5, 16'h0011);
        we = 1'b1; waddr = 4'd5; wdata = 16'h00AA; ra = 4'd5; rb = 4'd5;
        expect_("bypass_a", 0, 16'h00AA);
        expect_("bypass_b", 1, 16'h00AA);
        expect_("nobypass_a", 3, 16'h0011);
        expect_("nobypass_b", 4, 16'h0011);
        sample();
        tick();
        we = 1'b0;
        expect_("post_a", 0, 16'h00AA);
        expect_("post_b", 1, 16'h00AA);
        expect_("post_a2", 3, 16'h00AA);
        expect_("post_b2", 4, 16'h00AA);
        sample();

        // Clear timing.
        for (int i = 0; i < 16; i++) write(4'(i), 16'hA5A5);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        expect_("busy_high", 2, 16'h0001);
        expect_("busy2_high", 5, 16'h0001);
        sample();
        run_clear(1'b0);
        for (int i = 0; i < 16; i++) begin
            ra = 4'(i); rb = 4'(15 - i);
            expect_($sformatf("cleared_a_r%0d", i), 0, 16'h0000);
            expect_($sformatf("cleared_b2_r%0d", 15 - i), 4, 16'h0000);
            sample();
        end

        // Writes and requests while busy; write on the accepting edge.
        write(4'd9, 16'h1111);
        we = 1'b1; waddr = 4'd2; wdata = 16'h2222; clear_req = 1'b1;
        tick();
        we = 1'b0; clear_req = 1'b0;
        ra = 4'd2; rb = 4'd9;
        expect_("accept_edge_wr_r2", 0, 16'h2222);
        expect_("busy_r9_old", 1, 16'h1111);
        sample();
        run_clear(1'b1);
        expect_("r2_end_zero", 0, 16'h0000);
        expect_("r9_end_zero", 1, 16'h0000);
        sample();

        // Reset mid-clear.
        write(4'd12, 16'h5555);
        write(4'd14, 16'h6666);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        ra = 4'd12; rb = 4'd14;
        expect_("midclr_r12_kept", 0, 16'h5555);
        expect_("midclr_busy", 2, 16'h0001);
        sample();
        rst_n = 1'b0;
        expect_("midrst_busy", 2, 16'h0000);
        expect_("midrst_r12", 0, 16'h0000);
        expect_("midrst_r14", 1, 16'h0000);
        sample();
        rst_n = 1'b1;
        tick();
        write(4'd12, 16'h4242);
        expect_("post_rst_wr_r12", 0, 16'h4242);
        expect_("post_rst_busy", 2, 16'h0000);
        sample();

        #5;
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
